banco_registros_sb: RTL
=======================

BANCO_REGISTROS_SB -- requirements
Module: banco_registros_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 2..64); AW = clog2(NREG).
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-004 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port: RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: Add_A  in  AW  read port A address; Add_B  in  AW  read port B address.
REQ-007 SHALL have ports: Add_Dest  in  AW  writeback address; Write_Data  in  XLEN  writeback data; Write_En  in  1  writeback strobe.
REQ-008 SHALL have ports: Issue_En  in  1  reserve destination; Issue_Dest  in  AW  register reserved by issuing instruction.
REQ-009 SHALL have ports: Info_A  out  XLEN; Info_B  out  XLEN  read data.
REQ-010 SHALL have ports: Busy_A  out  1; Busy_B  out  1  pending-write flag of addressed register.
REQ-011 SHALL have port: Busy_Cnt  out  clog2(NREG+1)  number of registers currently reserved.

Function
REQ-012 Register 0 SHALL always read 0, never be written, never be busy.
REQ-013 Write: on rising CLK with Write_En=1 and Add_Dest!=0, reg[Add_Dest] SHALL take Write_Data.
REQ-014 Read SHALL be combinational: Info_X = reg[Add_X], zero latency.
REQ-015 BYPASS=1: Write_En=1, Add_Dest=Add_X!=0 SHALL make Info_X = Write_Data in same cycle; BYPASS=0: old value until next edge.
REQ-016 Scoreboard: busy[Issue_Dest] SHALL set on edge when Issue_En=1, Issue_Dest!=0.
REQ-017 busy[Add_Dest] SHALL clear on edge when Write_En=1, Add_Dest!=0.
REQ-018 Issue and writeback to same register in same cycle: busy SHALL end set (new reservation wins); data still written.
REQ-019 Issue to already-busy register (WAW): busy stays set, Busy_Cnt unchanged.
REQ-020 Writeback to non-busy register: data written, busy stays clear, Busy_Cnt unchanged.
REQ-021 Busy_X = busy[Add_X]; with BYPASS=1, SHALL read 0 when same-cycle writeback targets Add_X and no same-cycle issue to Add_X.
REQ-022 Busy_Cnt SHALL be registered and equal popcount(busy) after every edge: +1, -1 or 0 per cycle; never exceed NREG-1, never wrap.

Reset
REQ-023 RST_N low SHALL immediately, without CLK, clear all registers to 0, all busy bits, Busy_Cnt to 0.
REQ-024 Outputs during reset: Info_A/B = 0 except bypass path per REQ-015 (BYPASS=1); Busy_A/B = 0.
REQ-025 Write/issue strobes during reset SHALL be ignored; reset assertion mid-sequence SHALL discard all pending reservations.
REQ-026 First edge after RST_N rises SHALL process strobes normally.

Structure
REQ-027 Shared package banco_pkg SHALL hold default XLEN, NREG, and AW computation function.
REQ-028 Scoreboard (busy vector + Busy_Cnt) SHALL be sub-module scoreboard_regs; storage array stays in top.

Verification
REQ-029 Reset, then Write_En=1, write 30,20,25,5,8 to x0..x4; read A=3,B=1 -> Info_A=5, Info_B=20; A=2,B=0 -> 25, 0.
REQ-030 BYPASS=1: Add_A=7, Write_En=1, Add_Dest=7, Write_Data=4 same cycle -> Info_A=4 before edge; BYPASS=0 -> 0 until edge.
REQ-031 Issue x5 then x6 -> Busy_Cnt=2, Busy_A(A=5)=1; writeback x5 -> Busy_A=0, Busy_Cnt=1.
REQ-032 Same cycle Issue_Dest=6, Add_Dest=6 write 9 while x6 busy -> Busy stays 1, Busy_Cnt unchanged, reg6=9.
REQ-033 Issue_Dest=0 and write x0=0xFFFFFFFF -> Info_A(A=0)=0, Busy_A=0, Busy_Cnt unchanged.
REQ-034 Issue x1..x3, assert RST_N=0 between edges -> Busy_Cnt=0, Info all 0 immediately; no CLK edge needed.

Source files
------------

// File: rtl/banco_pkg.sv
// -----------------------------------------------------------------------------
// banco_pkg
// Shared defaults and width helper for the register bank and its scoreboard.
//   XLEN_DEF : default data width in bits
//   NREG_DEF : default number of architectural registers
//   calc_aw  : ceil(log2(n)), used for address and counter widths
// -----------------------------------------------------------------------------
package banco_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Smallest w such that 2**w >= n (n >= 1).
    function automatic int calc_aw(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/banco_registros_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// scoreboard_regs
// Pending-write tracking for the register bank: one busy bit per register plus
// a registered population count of those bits.
//   clk, rst_n            : clock, asynchronous active-low reset
//   add_a, add_b          : read addresses whose busy flags are reported
//   write_en, add_dest    : writeback strobe/address (clears a reservation)
//   issue_en, issue_dest  : issue strobe/address (sets a reservation)
//   busy_a, busy_b        : busy flag of the addressed registers
//   busy_cnt              : number of registers currently reserved
// -----------------------------------------------------------------------------
module scoreboard_regs
    import banco_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREG),
    localparam int CW    = calc_aw(NREG + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] add_a,
    input  logic [AW-1:0] add_b,
    input  logic          write_en,
    input  logic [AW-1:0] add_dest,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_dest,
    output logic          busy_a,
    output logic          busy_b,
    output logic [CW-1:0] busy_cnt
);

    logic [NREG-1:0] busy_r;
    logic [CW-1:0]   cnt_r;
    logic [NREG-1:0] set_s;
    logic [NREG-1:0] clr_s;
    logic [NREG-1:0] busy_nxt_s;
    logic            wr_hit_s;
    logic            iss_hit_s;
    logic            inc_s;
    logic            dec_s;
    logic            fwd_a_s;
    logic            fwd_b_s;

    // Next busy vector and counter deltas; register 0 can never be reserved.
    always_comb begin
        wr_hit_s   = write_en && (add_dest != {AW{1'b0}});
        iss_hit_s  = issue_en && (issue_dest != {AW{1'b0}});
        set_s      = iss_hit_s ? ({{(NREG-1){1'b0}}, 1'b1} << issue_dest) : {NREG{1'b0}};
        clr_s      = wr_hit_s  ? ({{(NREG-1){1'b0}}, 1'b1} << add_dest)   : {NREG{1'b0}};
        // Set is applied after clear so a same-cycle re-issue keeps the bit.
        busy_nxt_s = (busy_r & ~clr_s) | set_s;
        // Count only real 0->1 and 1->0 transitions, so WAW issues and
        // writebacks to idle registers leave the counter alone.
        inc_s      = iss_hit_s && !busy_r[issue_dest];
        dec_s      = wr_hit_s && busy_r[add_dest] &&
                     !(iss_hit_s && (issue_dest == add_dest));
    end

    // Busy flags seen by the read ports, with optional writeback forwarding.
    always_comb begin
        fwd_a_s = (BYPASS != 0) && wr_hit_s && (add_dest == add_a) &&
                  !(iss_hit_s && (issue_dest == add_a));
        fwd_b_s = (BYPASS != 0) && wr_hit_s && (add_dest == add_b) &&
                  !(iss_hit_s && (issue_dest == add_b));
        if (fwd_a_s) begin
            busy_a = 1'b0;
        end else begin
            busy_a = busy_r[add_a];
        end
        if (fwd_b_s) begin
            busy_b = 1'b0;
        end else begin
            busy_b = busy_r[add_b];
        end
    end

    // Busy vector and reservation counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_r + CW'(inc_s) - CW'(dec_s);
        end
    end

    assign busy_cnt = cnt_r;

endmodule

// File: rtl/banco_registros_sb.sv
// -----------------------------------------------------------------------------
// banco_registros_sb
// Register file with two combinational read ports, one write port, optional
// write-to-read forwarding and a busy scoreboard for pending writebacks.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   Add_A, Add_B          : read addresses
//   Add_Dest, Write_Data, Write_En : writeback port
//   Issue_En, Issue_Dest  : reserve a destination register
//   Info_A, Info_B        : read data (zero latency)
//   Busy_A, Busy_B        : pending-write flags of the read addresses
//   Busy_Cnt              : number of reserved registers
// Register 0 is hardwired to zero and is never reserved.
// -----------------------------------------------------------------------------
module banco_registros_sb
    import banco_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREG),
    localparam int CW    = calc_aw(NREG + 1)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   Add_A,
    input  logic [AW-1:0]   Add_B,
    input  logic [AW-1:0]   Add_Dest,
    input  logic [XLEN-1:0] Write_Data,
    input  logic            Write_En,
    input  logic            Issue_En,
    input  logic [AW-1:0]   Issue_Dest,
    output logic [XLEN-1:0] Info_A,
    output logic [XLEN-1:0] Info_B,
    output logic            Busy_A,
    output logic            Busy_B,
    output logic [CW-1:0]   Busy_Cnt
);

    logic [XLEN-1:0] regs_r [NREG];
    logic            wr_hit_s;

    assign wr_hit_s = Write_En && (Add_Dest != {AW{1'b0}});

    // Register storage; entry 0 is only ever loaded by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (wr_hit_s) begin
                regs_r[Add_Dest] <= Write_Data;
            end
        end
    end

    // Combinational read ports; forwarding stays live during reset as well.
    always_comb begin
        if ((BYPASS != 0) && wr_hit_s && (Add_Dest == Add_A)) begin
            Info_A = Write_Data;
        end else begin
            Info_A = regs_r[Add_A];
        end
        if ((BYPASS != 0) && wr_hit_s && (Add_Dest == Add_B)) begin
            Info_B = Write_Data;
        end else begin
            Info_B = regs_r[Add_B];
        end
    end

    scoreboard_regs #(
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (CLK),
        .rst_n      (RST_N),
        .add_a      (Add_A),
        .add_b      (Add_B),
        .write_en   (Write_En),
        .add_dest   (Add_Dest),
        .issue_en   (Issue_En),
        .issue_dest (Issue_Dest),
        .busy_a     (Busy_A),
        .busy_b     (Busy_B),
        .busy_cnt   (Busy_Cnt)
    );

endmodule
